// File: rtl/enc74148_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enc74148_pkg
//  Description : Shared types, constants and the priority helper for the
//                registered 8-to-3 priority encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package enc74148_pkg;

    typedef logic [2:0] code_t;

    localparam int N_REQ           = 8;
    localparam int DEF_SYNC_STAGES = 2;

    // Output-register state encoding
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // Index of the highest set bit; bit 7 has the highest priority.
    // Ascending scan, so later (higher) hits overwrite earlier ones.
    function automatic code_t prio8(input logic [7:0] i_vec);
        code_t v_idx;
        v_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i_vec[i]) begin
                v_idx = code_t'(i);
            end
        end
        return v_idx;
    endfunction

endpackage : enc74148_pkg
`default_nettype wire

// File: rtl/prio_encoder_74148_seq_sync_bank.sv
`default_nettype none
// ============================================================================
//  Module      : sync_bank
//  Description : Bank of multi-flop synchronizers for asynchronous active-low
//                request lines. Flops reset to all-ones (idle level).
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_bank
    import enc74148_pkg::*;
#(
    parameter int WIDTH  = N_REQ,
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_stage [STAGES];

    // Shift each request line through STAGES flops; reset to the idle level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < STAGES; s++) begin
                r_stage[s] <= '1;
            end
        end else begin
            r_stage[0] <= i_async;
            for (int s = 1; s < STAGES; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign o_sync = r_stage[STAGES-1];

endmodule : sync_bank
`default_nettype wire

// File: rtl/prio_encoder_74148_seq.sv
`default_nettype none
// ============================================================================
//  Module      : prio_encoder_74148_seq
//  Description : Registered 8-to-3 priority encoder. Synchronizes active-low
//                request lines, latches events into a pending vector and
//                presents the highest pending index both as 74148-style
//                active-low pins and as a binary code with valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_encoder_74148_seq
    import enc74148_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int EDGE_MODE   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ei_n_i,
    input  logic [N_REQ-1:0] req_n_i,
    input  logic             ready_i,
    output logic             valid_o,
    output code_t            code_o,
    output logic [2:0]       a_n_o,
    output logic             gs_n_o,
    output logic             eo_n_o,
    output logic [N_REQ-1:0] pend_o,
    output logic             ovr_o
);

    logic [N_REQ-1:0] w_sync;
    logic [N_REQ-1:0] w_event;
    logic [N_REQ-1:0] w_clr;
    logic             w_ovr_hit;

    logic [N_REQ-1:0] r_prev;
    logic [N_REQ-1:0] r_fall;
    logic [N_REQ-1:0] r_pend;
    logic             r_ovr;

    state_t           r_state;
    logic             r_valid;
    code_t            r_code;
    logic [2:0]       r_a_n;
    logic             r_gs_n;
    logic             r_eo_n;

    sync_bank #(
        .WIDTH  (N_REQ),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_async (req_n_i),
        .o_sync  (w_sync)
    );

    // Event source: a falling edge of the synchronized line, or its low level
    generate
        if (EDGE_MODE != 0) begin : g_edge
            assign w_event = r_prev & ~w_sync;
        end else begin : g_level
            assign w_event = ~w_sync;
        end
    endgenerate

    // The presented bit is cleared only on an actual handshake
    assign w_clr = (r_valid && ready_i) ? (8'b0000_0001 << r_code) : '0;

    // A new event landing on a bit that is still pending and not being
    // cleared this cycle means a lost event; meaningless in level mode
    assign w_ovr_hit = (EDGE_MODE != 0) && (|(r_fall & r_pend & ~w_clr));

    // Event capture and pending bookkeeping; a new event beats a clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prev <= '1;
            r_fall <= '0;
            r_pend <= '0;
            r_ovr  <= 1'b0;
        end else begin
            r_prev <= w_sync;
            r_fall <= w_event;
            r_pend <= (r_pend & ~w_clr) | r_fall;
            r_ovr  <= w_ovr_hit;
        end
    end

    // Output register: present one index at a time, frozen until accepted
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_code  <= '0;
            r_a_n   <= 3'b111;
            r_gs_n  <= 1'b1;
            r_eo_n  <= 1'b1;
        end else if (ei_n_i) begin
            // Disabled: outputs go inactive, code_o keeps its last value and
            // any unaccepted event stays pending for re-presentation
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_a_n   <= 3'b111;
            r_gs_n  <= 1'b1;
            r_eo_n  <= 1'b1;
        end else begin
            r_gs_n <= ~(|r_pend);
            r_eo_n <= |r_pend;
            case (r_state)
                ST_IDLE: begin
                    if (|r_pend) begin
                        r_code  <= prio8(r_pend);
                        r_a_n   <= ~prio8(r_pend);
                        r_valid <= 1'b1;
                        r_state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign valid_o = r_valid;
    assign code_o  = r_code;
    assign a_n_o   = r_a_n;
    assign gs_n_o  = r_gs_n;
    assign eo_n_o  = r_eo_n;
    assign pend_o  = r_pend;
    assign ovr_o   = r_ovr;

endmodule : prio_encoder_74148_seq
`default_nettype wire

// File: tb/tb_prio_encoder_74148_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prio_encoder_74148_seq
//  Description : Directed self-checking bench for prio_encoder_74148_seq
//                (SYNC_STAGES=2, EDGE_MODE=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_encoder_74148_seq;

    logic       clk_i;
    logic       rst_i;
    logic       ei_n_i;
    logic [7:0] req_n_i;
    logic       ready_i;
    logic       valid_o;
    logic [2:0] code_o;
    logic [2:0] a_n_o;
    logic       gs_n_o;
    logic       eo_n_o;
    logic [7:0] pend_o;
    logic       ovr_o;

    int n_vec;
    int n_err;

    prio_encoder_74148_seq #(
        .SYNC_STAGES (2),
        .EDGE_MODE   (1)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .ei_n_i  (ei_n_i),
        .req_n_i (req_n_i),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .code_o  (code_o),
        .a_n_o   (a_n_o),
        .gs_n_o  (gs_n_o),
        .eo_n_o  (eo_n_o),
        .pend_o  (pend_o),
        .ovr_o   (ovr_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One clock edge, then settle 1 ns so outputs are sampled away from it
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pres(input string tag, input logic [2:0] code);
        chk({tag, "_valid"}, {7'd0, valid_o}, 8'h01);
        chk({tag, "_code"},  {5'd0, code_o},  {5'd0, code});
        chk({tag, "_a_n"},   {5'd0, a_n_o},   {5'd0, ~code});
        chk({tag, "_gs_n"},  {7'd0, gs_n_o},  8'h00);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_i   = 1'b1;
        ei_n_i  = 1'b0;
        req_n_i = 8'h00;
        ready_i = 1'b0;

        // ---------------- reset ----------------
        step(2);
        chk("rst_valid", {7'd0, valid_o}, 8'h00);
        chk("rst_code",  {5'd0, code_o},  8'h00);
        chk("rst_a_n",   {5'd0, a_n_o},   8'h07);
        chk("rst_gs_n",  {7'd0, gs_n_o},  8'h01);
        chk("rst_eo_n",  {7'd0, eo_n_o},  8'h01);
        chk("rst_ovr",   {7'd0, ovr_o},   8'h00);
        chk("rst_pend",  pend_o,          8'h00);
        rst_i   = 1'b0;
        req_n_i = 8'hFF;
        step(1);
        chk("post_rst_pend", pend_o, 8'h00);
        step(4);
        chk("idle_eo_n", {7'd0, eo_n_o}, 8'h00);

        // ---------------- single event, bit 5 ----------------
        req_n_i = 8'hDF;
        step(4);                                  // after edge 3
        chk("single_pend_e3",  pend_o,          8'h20);
        chk("single_valid_e3", {7'd0, valid_o}, 8'h00);
        step(1);                                  // after edge 4
        chk_pres("single_e4", 3'd5);
        chk("single_eo_n", {7'd0, eo_n_o}, 8'h01);
        step(10);
        chk_pres("single_hold", 3'd5);
        ready_i = 1'b1;
        step(1);
        ready_i = 1'b0;
        chk("single_acc_pend",  pend_o,          8'h00);
        chk("single_acc_valid", {7'd0, valid_o}, 8'h00);
        step(1);
        chk("single_eo_after", {7'd0, eo_n_o}, 8'h00);
        chk("single_gs_after", {7'd0, gs_n_o}, 8'h01);
        step(6);
        chk("single_no_second_pend",  pend_o,          8'h00);
        chk("single_no_second_valid", {7'd0, valid_o}, 8'h00);
        req_n_i = 8'hFF;
        step(4);
        chk("single_rise_pend", pend_o, 8'h00);

        // ---------------- priority and freeze ----------------
        req_n_i = 8'hFB;
        step(5);
        chk_pres("freeze_first", 3'd2);
        req_n_i = 8'hBB;
        step(6);
        chk("freeze_pend", pend_o, 8'h44);
        chk_pres("freeze_hold", 3'd2);
        ready_i = 1'b1;
        step(1);
        ready_i = 1'b0;
        chk("freeze_bubble_valid", {7'd0, valid_o}, 8'h00);
        step(1);
        chk_pres("freeze_next", 3'd6);
        ready_i = 1'b1;
        step(1);
        ready_i = 1'b0;
        chk("freeze_done_pend", pend_o, 8'h00);
        req_n_i = 8'hFF;
        step(4);

        // ---------------- overrun ----------------
        req_n_i = 8'hF7;
        step(5);
        chk_pres("ovr_first", 3'd3);
        req_n_i = 8'hFF;
        step(1);
        req_n_i = 8'hF7;
        step(1);                                  // new fall sampled here
        step(2);
        chk("ovr_before", {7'd0, ovr_o}, 8'h00);
        step(1);
        chk("ovr_pulse", {7'd0, ovr_o}, 8'h01);
        step(1);
        chk("ovr_after", {7'd0, ovr_o}, 8'h00);
        chk_pres("ovr_still", 3'd3);

        // ---------------- set wins over clear ----------------
        req_n_i = 8'hFF;
        step(1);
        req_n_i = 8'hF7;
        step(1);
        step(2);
        ready_i = 1'b1;
        step(1);                                  // acceptance meets new event
        ready_i = 1'b0;
        chk("setwin_pend",  pend_o,          8'h08);
        chk("setwin_valid", {7'd0, valid_o}, 8'h00);
        chk("setwin_ovr",   {7'd0, ovr_o},   8'h00);
        step(1);
        chk_pres("setwin_repr", 3'd3);
        ready_i = 1'b1;
        step(1);
        ready_i = 1'b0;
        chk("setwin_done_pend", pend_o, 8'h00);
        req_n_i = 8'hFF;
        step(4);

        // ---------------- enable gating ----------------
        req_n_i = 8'hEF;
        step(5);
        chk_pres("en_first", 3'd4);
        ei_n_i = 1'b1;
        step(1);
        chk("dis_valid", {7'd0, valid_o}, 8'h00);
        chk("dis_a_n",   {5'd0, a_n_o},   8'h07);
        chk("dis_gs_n",  {7'd0, gs_n_o},  8'h01);
        chk("dis_eo_n",  {7'd0, eo_n_o},  8'h01);
        chk("dis_code",  {5'd0, code_o},  8'h04);
        chk("dis_pend",  pend_o,          8'h10);
        step(3);
        chk("dis_hold_valid", {7'd0, valid_o}, 8'h00);
        chk("dis_hold_pend",  pend_o,          8'h10);
        ei_n_i = 1'b0;
        step(1);
        chk_pres("en_repr", 3'd4);
        ready_i = 1'b1;
        step(1);
        ready_i = 1'b0;
        req_n_i = 8'hFF;
        step(4);
        chk("en_done_pend", pend_o, 8'h00);

        // ---------------- burst of all eight lines ----------------
        ready_i = 1'b1;
        req_n_i = 8'h00;
        step(5);                                  // after edge 4
        for (int k = 7; k >= 0; k--) begin
            chk_pres($sformatf("burst_c%0d", k), 3'(k));
            step(1);
            chk($sformatf("burst_gap%0d_valid", k), {7'd0, valid_o}, 8'h00);
            if (k > 0) begin
                chk($sformatf("burst_gap%0d_gs_n", k), {7'd0, gs_n_o}, 8'h00);
            end
            step(1);
        end
        chk("burst_end_eo_n",  {7'd0, eo_n_o},  8'h00);
        chk("burst_end_gs_n",  {7'd0, gs_n_o},  8'h01);
        chk("burst_end_valid", {7'd0, valid_o}, 8'h00);
        chk("burst_end_pend",  pend_o,          8'h00);
        step(5);
        chk("burst_held_pend", pend_o, 8'h00);
        ready_i = 1'b0;
        req_n_i = 8'hFF;
        step(4);

        // ---------------- reset mid-handshake ----------------
        req_n_i = 8'h7E;
        step(5);
        chk_pres("midrst_pres", 3'd7);
        rst_i   = 1'b1;
        req_n_i = 8'hFF;
        step(1);
        rst_i = 1'b0;
        chk("midrst_valid", {7'd0, valid_o}, 8'h00);
        chk("midrst_pend",  pend_o,          8'h00);
        step(6);
        chk("midrst_no_replay_valid", {7'd0, valid_o}, 8'h00);
        chk("midrst_no_replay_pend",  pend_o,          8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_prio_encoder_74148_seq
`default_nettype wire

// File: doc/prio_encoder_74148_seq.md
Name: prio_encoder_74148_seq

Overview:
- Registered 8-to-3 priority encoder: the encode-side counterpart of the team's 3-to-8 active-low decoder.
- Captures events on eight active-low request lines, keeps a pending bit per line, and presents the highest-priority pending index.
- Two output views of the same index: 74148-style active-low pins, and a true-binary code with a valid/ready handshake.
- Sits between external asynchronous request/interrupt pins and a consumer that acknowledges one event at a time.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per request line (legal values 2..4).
- EDGE_MODE, 1, 1 = capture a falling edge on the synchronized line; 0 = level mode, pending is set every cycle the line is low.

Ports:
- clk_i  input  1  single clock.
- rst_i  input  1  synchronous, active-high reset.
- ei_n_i  input  1  enable input, active-low; gates the outputs only.
- req_n_i  input  8  request lines, active-low, asynchronous; bit 7 is highest priority.
- ready_i  input  1  consumer accepts the presented code.
- valid_o  output  1  code_o holds a pending event.
- code_o  output  3  binary index of the presented event.
- a_n_o  output  3  inverted code_o (74148 A2..A0).
- gs_n_o  output  1  group select, active-low: enabled and at least one bit pending.
- eo_n_o  output  1  enable out, active-low: enabled and nothing pending.
- pend_o  output  8  current pending vector.
- ovr_o  output  1  one-cycle overrun pulse.

Behaviour:
- Reset values, on the first rising clk_i edge with rst_i high:
  - synchronizer and previous-value flops = 8'hFF; pend_o = 0;
  - valid_o = 0, code_o = 0, a_n_o = 3'b111, gs_n_o = 1, eo_n_o = 1, ovr_o = 0.
- Reset mid-handshake discards all pending events; nothing is replayed afterwards.
- Synchronization: each req_n_i bit passes through SYNC_STAGES flops, giving s[i].
- Event detect, per bit:
  - EDGE_MODE=1: fall[i] = prev[i] & ~s[i], where prev is s delayed one cycle.
  - EDGE_MODE=0: fall[i] = ~s[i].
- Pending update, per cycle:
  - pend_next = (pend & ~clr) | fall.
  - clr is one-hot at code_o when valid_o & ready_i, else 0.
  - If set and clear hit the same bit in the same cycle, set wins; the new edge is a new event.
- Overrun: ovr_o = 1 for one cycle after any cycle where fall[i] & pend[i] & ~clr[i] for some i. This applies only when EDGE_MODE=1; when EDGE_MODE=0, ovr_o is held 0.
- Latency (EDGE_MODE=1): the first clk_i edge that samples a low req_n_i is edge 0.
  - pend_o bit sets at edge SYNC_STAGES+1.
  - valid_o, code_o, a_n_o and gs_n_o update at edge SYNC_STAGES+2.
  - Default SYNC_STAGES=2: valid_o rises 4 cycles after the sampling edge.
- Output register, two states:
  - IDLE (valid_o=0): if ei_n_i=0 and pend≠0, load code_o with the index of the highest set bit and go to PRESENT.
  - PRESENT (valid_o=1): code_o, a_n_o and valid_o are frozen while ready_i=0, even if a higher-priority bit becomes pending.
  - PRESENT with ready_i=1: the bit is cleared and the block returns to IDLE. The next code is loaded no earlier than the following edge, so there is one bubble cycle between accepted codes.
- Enable:
  - ei_n_i=1 forces the next-cycle outputs to valid_o=0, a_n_o=3'b111, gs_n_o=1, eo_n_o=1. code_o holds its last value.
  - Capture into pend continues while disabled.
  - ei_n_i rising during PRESENT without ready_i drops valid_o with no clear; the event stays pending and is re-presented once enabled.
- Flag registration: gs_n_o and eo_n_o are registered from the current pend and ei_n_i.
  - Exactly one of gs_n_o/eo_n_o is low when enabled; both are high when disabled.
  - gs_n_o = ~valid_o whenever enabled, except during the bubble cycle.
- Boundaries:
  - All eight lines fall in the same cycle: served in order 7,6,...,0, at one acceptance per 2 cycles with ready_i held high.
  - Line held low with EDGE_MODE=1: one event only.
  - Line held low with EDGE_MODE=0: the bit re-sets immediately after each clear.

Decomposition:
- Package enc74148_pkg:
  - typedef code_t = logic [2:0];
  - localparam N_REQ = 8;
  - function prio8(logic [7:0]) returns code_t, the highest set index.
  - localparam default SYNC_STAGES.
- Sub-module sync_bank (width, stages parameters) for the synchronizer flops.
- Edge detect, pending, FSM and output register stay in the top module.

Test Plan:
- Reset: rst_i high for 2 cycles with req_n_i=8'h00 -> all outputs at reset values; pend_o=0 on the cycle after release.
- Single event: ei_n_i=0, drive req_n_i bit 5 low (8'hDF) and hold, ready_i=0 -> pend_o=8'h20 at edge 3; valid_o=1, code_o=5, a_n_o=3'b010, gs_n_o=0 at edge 4; values hold for 10 cycles; pulse ready_i -> pend_o=0, eo_n_o=0, no second event.
- Priority and freeze: bit 2 is pending and presented, then bit 6 falls while ready_i=0 -> code_o stays 2 until accepted; the next presented code is 6.
- Burst: req_n_i goes 8'hFF->8'h00 in one cycle, ready_i=1 -> codes 7,6,5,4,3,2,1,0, each valid for 1 cycle with a 1-cycle gap, then eo_n_o=0.
- Overrun and set-wins:
  - Toggle bit 3 twice while it is pending and unaccepted -> ovr_o pulses once.
  - Make a new bit-3 fall coincide with its acceptance -> pend_o[3] stays 1 and the event is re-presented.
- Enable gating: assert ei_n_i=1 during PRESENT with ready_i=0 -> valid_o=0, a_n_o=3'b111, gs_n_o=eo_n_o=1, pend_o unchanged; deassert -> the same code is re-presented.
